camera_motion_ctrl: RTL and testbench
=====================================

// Module: camera_motion_ctrl
// PURPOSE
//  Per-frame motion scheduler between keyboard_decoder and the ray-marcher camera registers.
//  Snapshots the held-key vector at each frame start and waits until the renderer is idle.
//  Then sequences yaw and X/Y/Z position updates, one per cycle, with a speed ramp.
//  Commits the new camera state atomically with a one-cycle valid pulse.
// PARAMETERS
//  POS_W      16  width of signed camera position registers (two's complement)
//  YAW_W      8   width of unsigned yaw index; wraps modulo 2^YAW_W
//  BASE_STEP  4   translation step per frame when a move key is first held
//  MAX_RAMP   12  cap on extra step added by ramp counter
//  TURN_STEP  2   yaw change per frame while a turn key is held
// PORTS
//  clk_in          in   1      system clock
//  rst_n_in        in   1      asynchronous, active-low reset
//  kb_in           in   8      held-key vector, bit indices per `KB_* defines in types.svh
//  frame_start_in  in   1      one-cycle pulse at start of each frame
//  render_busy_in  in   1      high while ray marcher reads camera state; no commit while high
//  cam_x_out       out  POS_W  committed lateral position (TRANS_RIGHT +, TRANS_LEFT -)
//  cam_y_out       out  POS_W  committed vertical position (TRANS_UP +, TRANS_DOWN -)
//  cam_z_out       out  POS_W  committed depth position (FORWARD +, BACKWARD -)
//  cam_yaw_out     out  YAW_W  committed yaw index (TURN_RIGHT +, TURN_LEFT -)
//  cam_valid_out   out  1      one-cycle pulse: cam_*_out just updated
//  frame_drop_out  out  1      one-cycle pulse: frame_start_in arrived while not IDLE
// BEHAVIOUR
//  Reset (async, immediate, any state): state=IDLE.
//   All cam_*_out, working regs, snapshot, ramp = 0; cam_valid_out = frame_drop_out = 0.
//  FSM: IDLE -> WAIT -> YAW -> POS_X -> POS_Y -> POS_Z -> COMMIT -> IDLE.
//   IDLE: on frame_start_in, latch kb_in into snapshot and go to WAIT.
//   WAIT: stay while render_busy_in=1; advance when render_busy_in=0.
//   YAW/POS_X/POS_Y/POS_Z: one working register updated per cycle from snapshot, unconditional advance.
//   COMMIT: copy working regs to cam_*_out, assert cam_valid_out, return to IDLE.
//  Latency: frame_start_in sampled at edge t with busy low throughout.
//   Outputs and cam_valid_out change at edge t+7; cam_valid_out high for exactly one cycle.
//  frame_start_in in any non-IDLE state: ignored, frame_drop_out pulses next cycle, snapshot unchanged.
//  Step: step = BASE_STEP + ramp.
//   ramp is updated in COMMIT: +1 (saturating at MAX_RAMP) if any translation axis moved this frame.
//   Otherwise ramp is cleared to 0. A single shared ramp covers all axes.
//  Per axis: only + key -> +step; only - key -> -step; both or neither -> no change.
//   Opposing keys on one axis count as not moved for ramp purposes.
//  Position arithmetic saturates at +(2^(POS_W-1)-1) and -(2^(POS_W-1)); no wrap.
//  Yaw: +/-TURN_STEP modulo 2^YAW_W (wraps); both turn keys -> no change. Yaw never affects ramp.
//  render_busy_in is sampled only in WAIT; busy rising after WAIT does not stall the sequence.
//  kb_in changes after the snapshot affect the next frame only.
// TESTING
//  Reset: rst_n_in low mid-POS_Y -> all outputs 0 within same cycle, state IDLE, no valid pulse.
//  FORWARD held 3 frames, busy low -> cam_z_out=4,9,15; valid pulses 7 cycles after each frame_start.
//  FORWARD held 20 frames -> step caps at 16 from frame 13; release 1 frame -> next press step=4.
//  TURN_LEFT from yaw=1 -> yaw 255; TURN_LEFT+TURN_RIGHT together -> yaw unchanged.
//  busy high 10 cycles after frame_start -> valid at edge t+17; 2nd frame_start in WAIT -> frame_drop_out=1.
//  cam_x_out=32765, TRANS_RIGHT held -> 32767 then stays 32767; TRANS_UP+TRANS_DOWN -> y unchanged, ramp 0.

Source files
------------

// File: rtl/camera_motion_ctrl.sv
// Per-frame camera motion scheduler.
// A held-key snapshot taken at frame start drives one yaw update and three
// position updates, issued one per cycle once the renderer is idle. The new
// camera state is then published in a single cycle with a one-cycle valid pulse.
//
// Handshake: frame_start_in is a fire-and-forget pulse; it is accepted only in
// IDLE, and any pulse seen elsewhere is dropped and reported on frame_drop_out.
// render_busy_in is a stall input that is honoured only in WAIT. cam_valid_out
// is a one-cycle strobe that the consumer cannot back-pressure.
module camera_motion_ctrl #(
  parameter int POS_W     = 16,
  parameter int YAW_W     = 8,
  parameter int BASE_STEP = 4,
  parameter int MAX_RAMP  = 12,
  parameter int TURN_STEP = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [7:0]              kb_in,
  input  logic                    frame_start_in,
  input  logic                    render_busy_in,
  output logic signed [POS_W-1:0] cam_x_out,
  output logic signed [POS_W-1:0] cam_y_out,
  output logic signed [POS_W-1:0] cam_z_out,
  output logic [YAW_W-1:0]        cam_yaw_out,
  output logic                    cam_valid_out,
  output logic                    frame_drop_out,
  output logic [2:0]              state_dbg_out
);

  // Held-key bit positions in kb_in
  localparam int KB_FORWARD     = 0;
  localparam int KB_BACKWARD    = 1;
  localparam int KB_TRANS_LEFT  = 2;
  localparam int KB_TRANS_RIGHT = 3;
  localparam int KB_TRANS_UP    = 4;
  localparam int KB_TRANS_DOWN  = 5;
  localparam int KB_TURN_LEFT   = 6;
  localparam int KB_TURN_RIGHT  = 7;

  localparam int RAMP_W = $clog2(MAX_RAMP + 1);
  localparam logic signed [POS_W:0] POS_MAX = {2'b00, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W:0] POS_MIN = {2'b11, {(POS_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_YAW    = 3'd2,
    S_POS_X  = 3'd3,
    S_POS_Y  = 3'd4,
    S_POS_Z  = 3'd5,
    S_COMMIT = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              snap_q, snap_d;
  logic signed [POS_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [YAW_W-1:0]        yaw_q, yaw_d;
  logic [RAMP_W-1:0]       ramp_q, ramp_d;
  logic                    moved_q, moved_d;
  logic                    pend_q, pend_d;
  logic signed [POS_W-1:0] cam_x_q, cam_x_d, cam_y_q, cam_y_d, cam_z_q, cam_z_d;
  logic [YAW_W-1:0]        cam_yaw_q, cam_yaw_d;
  logic                    valid_q, valid_d, drop_q, drop_d;
  logic [POS_W-1:0]        step;

  // Opposing keys cancel; result clamps to the signed range instead of wrapping.
  function automatic logic signed [POS_W-1:0] axis_next(
    input logic signed [POS_W-1:0] cur,
    input logic                    inc,
    input logic                    dec,
    input logic [POS_W-1:0]        stp
  );
    logic signed [POS_W:0] sum;
    sum = {cur[POS_W-1], cur};
    if (inc && !dec)      sum = sum + $signed({1'b0, stp});
    else if (dec && !inc) sum = sum - $signed({1'b0, stp});
    if (sum > POS_MAX)      sum = POS_MAX;
    else if (sum < POS_MIN) sum = POS_MIN;
    return sum[POS_W-1:0];
  endfunction

  assign step = POS_W'(BASE_STEP) + POS_W'(ramp_q);

  // Next-state, working-register and output-register logic
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    yaw_d     = yaw_q;
    ramp_d    = ramp_q;
    moved_d   = moved_q;
    pend_d    = 1'b0;
    cam_x_d   = cam_x_q;
    cam_y_d   = cam_y_q;
    cam_z_d   = cam_z_q;
    cam_yaw_d = cam_yaw_q;
    valid_d   = 1'b0;
    drop_d    = frame_start_in && (state_q != S_IDLE);

    // Publish stage: working regs are stable here (they only change in YAW..POS_Z).
    if (pend_q) begin
      cam_x_d   = x_q;
      cam_y_d   = y_q;
      cam_z_d   = z_q;
      cam_yaw_d = yaw_q;
      valid_d   = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start_in) begin
          snap_d  = kb_in;
          moved_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!render_busy_in) state_d = S_YAW;
      end
      S_YAW: begin
        if (snap_q[KB_TURN_RIGHT] && !snap_q[KB_TURN_LEFT])
          yaw_d = yaw_q + YAW_W'(TURN_STEP);
        else if (snap_q[KB_TURN_LEFT] && !snap_q[KB_TURN_RIGHT])
          yaw_d = yaw_q - YAW_W'(TURN_STEP);
        state_d = S_POS_X;
      end
      S_POS_X: begin
        x_d     = axis_next(x_q, snap_q[KB_TRANS_RIGHT], snap_q[KB_TRANS_LEFT], step);
        moved_d = moved_q | (snap_q[KB_TRANS_RIGHT] ^ snap_q[KB_TRANS_LEFT]);
        state_d = S_POS_Y;
      end
      S_POS_Y: begin
        y_d     = axis_next(y_q, snap_q[KB_TRANS_UP], snap_q[KB_TRANS_DOWN], step);
        moved_d = moved_q | (snap_q[KB_TRANS_UP] ^ snap_q[KB_TRANS_DOWN]);
        state_d = S_POS_Z;
      end
      S_POS_Z: begin
        z_d     = axis_next(z_q, snap_q[KB_FORWARD], snap_q[KB_BACKWARD], step);
        moved_d = moved_q | (snap_q[KB_FORWARD] ^ snap_q[KB_BACKWARD]);
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        pend_d = 1'b1;
        if (!moved_q)                          ramp_d = '0;
        else if (ramp_q != RAMP_W'(MAX_RAMP)) ramp_d = ramp_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and register update with asynchronous clear
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      snap_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      yaw_q     <= '0;
      ramp_q    <= '0;
      moved_q   <= 1'b0;
      pend_q    <= 1'b0;
      cam_x_q   <= '0;
      cam_y_q   <= '0;
      cam_z_q   <= '0;
      cam_yaw_q <= '0;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      yaw_q     <= yaw_d;
      ramp_q    <= ramp_d;
      moved_q   <= moved_d;
      pend_q    <= pend_d;
      cam_x_q   <= cam_x_d;
      cam_y_q   <= cam_y_d;
      cam_z_q   <= cam_z_d;
      cam_yaw_q <= cam_yaw_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
    end
  end

  assign cam_x_out      = cam_x_q;
  assign cam_y_out      = cam_y_q;
  assign cam_z_out      = cam_z_q;
  assign cam_yaw_out    = cam_yaw_q;
  assign cam_valid_out  = valid_q;
  assign frame_drop_out = drop_q;
  assign state_dbg_out  = state_q;

endmodule

// File: tb/tb_camera_motion_ctrl.sv
// Directed bench for camera_motion_ctrl: per-frame expected camera state,
// commit latency, ramp behaviour, saturation, yaw wrap and reset.
module tb_camera_motion_ctrl;

  localparam logic [7:0] FWD   = 8'h01;
  localparam logic [7:0] BACK  = 8'h02;
  localparam logic [7:0] LEFT  = 8'h04;
  localparam logic [7:0] RIGHT = 8'h08;
  localparam logic [7:0] UP    = 8'h10;
  localparam logic [7:0] DOWN  = 8'h20;
  localparam logic [7:0] TL    = 8'h40;
  localparam logic [7:0] TR    = 8'h80;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [7:0]         kb_in;
  logic               frame_start_in;
  logic               render_busy_in;
  logic signed [15:0] cam_x_out, cam_y_out, cam_z_out;
  logic [7:0]         cam_yaw_out;
  logic               cam_valid_out, frame_drop_out;
  logic [2:0]         state_dbg_out;

  int n_vec = 0;
  int n_err = 0;

  camera_motion_ctrl dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .kb_in          (kb_in),
    .frame_start_in (frame_start_in),
    .render_busy_in (render_busy_in),
    .cam_x_out      (cam_x_out),
    .cam_y_out      (cam_y_out),
    .cam_z_out      (cam_z_out),
    .cam_yaw_out    (cam_yaw_out),
    .cam_valid_out  (cam_valid_out),
    .frame_drop_out (frame_drop_out),
    .state_dbg_out  (state_dbg_out)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, cam_x_out, 0);
    check({tag, "_y"}, cam_y_out, 0);
    check({tag, "_z"}, cam_z_out, 0);
    check({tag, "_yaw"}, cam_yaw_out, 0);
    check({tag, "_valid"}, cam_valid_out, 0);
    check({tag, "_drop"}, frame_drop_out, 0);
    check({tag, "_state"}, state_dbg_out, 0);
  endtask

  // One frame: pulse frame_start with kb, scramble kb after the snapshot,
  // optionally hold busy and inject a second frame_start, then check the commit.
  task automatic do_frame(input logic [7:0] kb, input int busy_cyc, input int drop_at,
                          input int ex, input int ey, input int ez, input int eyaw);
    int n;
    @(negedge clk);
    kb_in          = kb;
    frame_start_in = 1'b1;
    render_busy_in = (busy_cyc > 0);
    @(posedge clk);
    @(negedge clk);
    frame_start_in = 1'b0;
    kb_in          = 8'($urandom);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (drop_at != 0 && n == drop_at + 1) check("frame_drop", frame_drop_out, 1);
      frame_start_in = (drop_at != 0 && n == drop_at);
      if (n == busy_cyc) render_busy_in = 1'b0;
      if (cam_valid_out) break;
    end
    frame_start_in = 1'b0;
    render_busy_in = 1'b0;
    check("latency", n, 7 + busy_cyc);
    check("cam_x", cam_x_out, ex);
    check("cam_y", cam_y_out, ey);
    check("cam_z", cam_z_out, ez);
    check("cam_yaw", cam_yaw_out, eyaw);
    @(posedge clk);
    #1;
    check("valid_width", cam_valid_out, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Watchdog
  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  // Stimulus and checks
  initial begin
    int ez, ex;
    int sat_frames;
    rst_n          = 1'b0;
    kb_in          = 8'h00;
    frame_start_in = 1'b0;
    render_busy_in = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Forward ramp: steps 4, 5, 6
    do_frame(FWD, 0, 0, 0, 0, 4, 0);
    do_frame(FWD, 0, 0, 0, 0, 9, 0);
    do_frame(FWD, 0, 0, 0, 0, 15, 0);
    do_frame(8'h00, 0, 0, 0, 0, 15, 0);

    // 20 held frames: step 4 + min(k,12), capping at 16 from frame 13
    ez = 15;
    for (int k = 0; k < 20; k++) begin
      ez = ez + 4 + ((k < 12) ? k : 12);
      do_frame(FWD, 0, 0, 0, 0, ez, 0);
    end
    check("z_after_20", ez, 257);
    do_frame(8'h00, 0, 0, 0, 0, 257, 0);
    do_frame(FWD, 0, 0, 0, 0, 261, 0);

    // Yaw wraps and cancels; turning alone clears the ramp
    do_frame(TL, 0, 0, 0, 0, 261, 254);
    do_frame(TL, 0, 0, 0, 0, 261, 252);
    do_frame(TR, 0, 0, 0, 0, 261, 254);
    do_frame(TL | TR, 0, 0, 0, 0, 261, 254);
    do_frame(TR, 0, 0, 0, 0, 261, 0);
    do_frame(FWD, 0, 0, 0, 0, 265, 0);
    do_frame(FWD, 0, 0, 0, 0, 270, 0);

    // Opposing vertical keys: no move, ramp cleared
    do_frame(UP | DOWN, 0, 0, 0, 0, 270, 0);
    do_frame(FWD, 0, 0, 0, 0, 274, 0);

    // Mixed axes: ramp 1 -> step 5, then ramp 2 -> step 6
    do_frame(FWD | BACK | RIGHT, 0, 0, 5, 0, 274, 0);
    do_frame(LEFT | UP | BACK, 0, 0, -1, 6, 268, 0);

    // Busy for 10 cycles with a second frame_start in WAIT; ramp 3 -> step 7
    do_frame(FWD, 10, 2, -1, 6, 275, 0);

    // Reset asserted mid-POS_Y
    @(negedge clk);
    kb_in          = FWD;
    frame_start_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_start_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_state", state_dbg_out, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("reset_valid", cam_valid_out, 0);
      check("reset_state", state_dbg_out, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Positive saturation on X
    ex = 0;
    sat_frames = 0;
    for (int k = 0; k < 2200 && sat_frames < 3; k++) begin
      ex = ex + 4 + ((k < 12) ? k : 12);
      if (ex > 32767) ex = 32767;
      if (ex == 32767) sat_frames++;
      do_frame(RIGHT, 0, 0, ex, 0, 0, 0);
    end
    check("x_pos_sat_reached", sat_frames, 3);

    // Negative saturation on X from a fresh reset
    apply_reset();
    ex = 0;
    sat_frames = 0;
    for (int k = 0; k < 2200 && sat_frames < 3; k++) begin
      ex = ex - 4 - ((k < 12) ? k : 12);
      if (ex < -32768) ex = -32768;
      if (ex == -32768) sat_frames++;
      do_frame(LEFT, 0, 0, ex, 0, 0, 0);
    end
    check("x_neg_sat_reached", sat_frames, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
